// File: rtl/descrambler.sv
// descrambler: additive 4-bit descrambler with Galois LFSR keystream and output FIFO
// Ports: CLK/RST (async active-high); in_data+EN_in/RDY_in push scrambled nibbles;
// seed_value+EN_seed/RDY_seed reload the LFSR; EN_out/RDY_out pop, out shows FIFO head;
// count is FIFO occupancy; err is a sticky protocol error, built only when
// DESCRAMBLER_PROTO_CHK_EN is defined (tied to 0 otherwise).
module descrambler #(
    parameter int         DEPTH      = 4,
    parameter logic [3:0] INIT_STATE = 4'h1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [3:0]               in_data,
    input  logic                     EN_in,
    output logic                     RDY_in,
    input  logic [3:0]               seed_value,
    input  logic                     EN_seed,
    output logic                     RDY_seed,
    input  logic                     EN_out,
    output logic [3:0]               out,
    output logic                     RDY_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [3:0]    lfsr_q, lfsr_d, lfsr_nxt;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic [3:0]    mem_q [DEPTH];
    logic          push, pop;

    assign RDY_in   = count_q != FULL;
    assign RDY_out  = count_q != '0;
    assign RDY_seed = 1'b1;
    assign count    = count_q;
    assign out      = RDY_out ? mem_q[rd_q] : 4'h0;
    assign push     = EN_in && RDY_in;
    assign pop      = EN_out && RDY_out;

    // Galois step: right shift, XOR 4'h9 when the bit shifted out was 1
    assign lfsr_nxt = lfsr_q[0] ? {1'b1, lfsr_q[3:2], ~lfsr_q[1]} : {1'b0, lfsr_q[3:1]};

    always_comb begin
        lfsr_d  = EN_seed ? seed_value : push ? lfsr_nxt : lfsr_q;
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = (push && !pop) ? count_q + 1'b1 :
                  (pop && !push) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr_q  <= INIT_STATE;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: out is gated by RDY_out
    always_ff @(posedge CLK) begin
        if (push)
            mem_q[wr_q] <= in_data ^ lfsr_q;
    end

`ifdef DESCRAMBLER_PROTO_CHK_EN
    logic err_q, err_d;
    assign err = err_q;
    // set wins over seed-clear
    assign err_d = ((EN_in && !RDY_in) || (EN_out && !RDY_out)) ? 1'b1 :
                   EN_seed ? 1'b0 : err_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_descrambler.sv
// tb_descrambler: scoreboard bench for descrambler with directed vectors
module tb_descrambler;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       EN_in = 1'b0;
    logic       RDY_in;
    logic [3:0] seed_value = 4'h0;
    logic       EN_seed = 1'b0;
    logic       RDY_seed;
    logic       EN_out = 1'b0;
    logic [3:0] out;
    logic       RDY_out;
    logic [2:0] count;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q [$];
    logic [3:0] ks [15] = '{4'h1, 4'h9, 4'hD, 4'hF, 4'hE, 4'h7, 4'hA, 4'h5,
                            4'hB, 4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2};
    logic exp_err;

    descrambler #(.DEPTH(4), .INIT_STATE(4'h1)) dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .EN_in(EN_in), .RDY_in(RDY_in),
        .seed_value(seed_value), .EN_seed(EN_seed), .RDY_seed(RDY_seed),
        .EN_out(EN_out), .out(out), .RDY_out(RDY_out), .count(count), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_q.delete();
    endtask

    task automatic push(input logic [3:0] d, input logic [3:0] e, input bit acc);
        EN_in = 1'b1;
        in_data = d;
        if (acc) exp_q.push_back(e);
        tick();
        EN_in = 1'b0;
    endtask

    task automatic pop();
        EN_out = 1'b1;
        tick();
        EN_out = 1'b0;
    endtask

    task automatic pushpop(input logic [3:0] d, input logic [3:0] e);
        EN_in = 1'b1;
        EN_out = 1'b1;
        in_data = d;
        exp_q.push_back(e);
        tick();
        EN_in = 1'b0;
        EN_out = 1'b0;
    endtask

    task automatic seed(input logic [3:0] s);
        EN_seed = 1'b1;
        seed_value = s;
        tick();
        EN_seed = 1'b0;
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge CLK);
            if (EN_out && RDY_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %0h expected no data", out);
                end else begin
                    e = exp_q.pop_front();
                    chk("out", {4'h0, out}, {4'h0, e});
                end
            end else if (EN_out && exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL pop_stalled: RDY_out 0 expected 1 with %0d queued", exp_q.size());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        do_reset();
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_rdy_in", 8'(RDY_in), 8'd1);
        chk("rst_rdy_out", 8'(RDY_out), 8'd0);
        chk("rst_out", 8'(out), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        chk("rdy_seed", 8'(RDY_seed), 8'd1);

        // data equal to keystream descrambles to zero
        push(4'h1, 4'h0, 1);
        chk("latency_rdy_out", 8'(RDY_out), 8'd1);
        chk("latency_out", 8'(out), 8'd0);
        push(4'h9, 4'h0, 1);
        push(4'hD, 4'h0, 1);
        push(4'hF, 4'h0, 1);
        repeat (4) pop();
        chk("t1_count", 8'(count), 8'd0);

        // zeros expose the keystream, wrapping after 15
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push(4'h0, ks[i % 15], 1);
            pop();
        end

        // seeding
        seed(4'hA);
        push(4'h0, 4'hA, 1);
        push(4'h0, 4'h5, 1);
        pop();
        pop();
        do_reset();
        EN_seed = 1'b1;
        seed_value = 4'h7;
        push(4'h0, 4'h1, 1);
        EN_seed = 1'b0;
        push(4'h0, 4'h7, 1);
        pop();
        pop();

        // overflow and underflow
        do_reset();
        for (int i = 0; i < 4; i++) push(4'h3, 4'h3 ^ ks[i], 1);
        chk("full_rdy_in", 8'(RDY_in), 8'd0);
        push(4'hC, 4'h0, 0);
        chk("full_count", 8'(count), 8'd4);
`ifdef DESCRAMBLER_PROTO_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        chk("ovf_err", 8'(err), 8'(exp_err));
        repeat (4) pop();
        chk("drain_count", 8'(count), 8'd0);
        pop();
        chk("udf_count", 8'(count), 8'd0);
        chk("udf_err", 8'(err), 8'(exp_err));
        push(4'h0, ks[4], 1);
        pop();
        seed(4'h1);
        chk("err_clear", 8'(err), 8'd0);

        // steady-state push+pop at count 2
        do_reset();
        push(4'h3, 4'h2, 1);
        push(4'h6, 4'hF, 1);
        for (int i = 0; i < 20; i++) begin
            pushpop(4'(i) ^ 4'h5, (4'(i) ^ 4'h5) ^ ks[(i + 2) % 15]);
            chk("pp_count", 8'(count), 8'd2);
        end
        pop();
        pop();

        // asynchronous reset mid-cycle
        do_reset();
        for (int i = 0; i < 3; i++) push(4'hF, 4'hF ^ ks[i], 1);
        #3;
        RST = 1'b1;
        #1;
        chk("async_rdy_out", 8'(RDY_out), 8'd0);
        chk("async_count", 8'(count), 8'd0);
        exp_q.delete();
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        push(4'h0, 4'h1, 1);
        pop();

        chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
